// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the program-load controller: FSM state encoding
// and default geometry of the instruction memory and load timeout.
package prog_load_ctrl_pkg;

  localparam int ADDR_W_DEF  = 14;
  localparam int TIMEOUT_DEF = 100000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

endpackage

// File: rtl/prog_load_ctrl_word_packer.sv
// Little-endian byte-to-word packer. The word output already includes the
// byte being accepted, so a completed word is available in the same cycle
// as its 4th byte. The pack register is zeroed after every completed or
// flushed word, which gives the zero fill of a partial word for free.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic [1:0]  byte_idx,
  output logic        word_done,
  output logic [31:0] word
);

  logic [31:0] pack_p0;

  assign word_done = accept && (byte_idx == 2'd3);

  // Byte position within the current word; wraps naturally after the 4th byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= 2'd0;
    end else if (clr || flush) begin
      byte_idx <= 2'd0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Pack register: data only, cleared whenever a word leaves or a load starts.
  always_ff @(posedge clk) begin
    if (clr || flush || word_done) begin
      pack_p0 <= '0;
    end else if (accept) begin
      pack_p0[{byte_idx, 3'b000} +: 8] <= byte_in;
    end
  end

  // Outgoing word, merging the top byte when it arrives this cycle.
  always_comb begin
    word = pack_p0;
    if (word_done) begin
      word[31:24] = byte_in;
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Program-load controller: holds the CPU in reset while UART bytes are
// packed into 32-bit words and written to consecutive instruction-memory
// addresses, then releases the CPU when the board switch returns to run.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_sel,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              cpu_hold,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              load_done,
  output logic              err
);

  localparam int                TCNT_W    = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              accept;
  logic              flush_req;
  logic              enter_wait;
  logic              tcnt_clr;
  logic              tcnt_inc;
  logic [1:0]        byte_idx;
  logic              word_done;
  logic [31:0]       pk_word;

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (enter_wait),
    .accept    (accept),
    .byte_in   (rx_data),
    .flush     (flush_req),
    .byte_idx  (byte_idx),
    .word_done (word_done),
    .word      (pk_word)
  );

  assign cpu_hold  = (state != S_RUN);
  assign load_done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus per-cycle control strobes. A byte arriving while the
  // switch is leaving load mode is dropped; a byte beats timeout expiry.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    flush_req  = 1'b0;
    enter_wait = 1'b0;
    tcnt_clr   = 1'b0;
    tcnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt  = mode_sel ? S_WAIT : S_RUN;
        enter_wait = mode_sel;
      end
      S_RUN: begin
        if (mode_sel) begin
          state_nxt  = S_WAIT;
          enter_wait = 1'b1;
        end
      end
      S_WAIT: begin
        if (!mode_sel) begin
          state_nxt = S_RUN;
        end else if (rx_valid) begin
          state_nxt = S_LOAD;
          accept    = 1'b1;
          tcnt_clr  = 1'b1;
        end
      end
      S_LOAD: begin
        if (!mode_sel || (!rx_valid && tcnt == TCNT_LAST)) begin
          state_nxt = (byte_idx != 2'd0) ? S_FLUSH : S_DONE;
          flush_req = (byte_idx != 2'd0);
        end else if (rx_valid) begin
          accept   = 1'b1;
          tcnt_clr = 1'b1;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      S_FLUSH: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!mode_sel) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Idle-cycle counter that ends a load after TIMEOUT quiet cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (enter_wait || tcnt_clr) begin
      tcnt <= '0;
    end else if (tcnt_inc) begin
      tcnt <= tcnt + TCNT_W'(1);
    end
  end

  // Registered write port, word counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (enter_wait) begin
        word_cnt <= '0;
        err      <= 1'b0;
      end else if (word_done || flush_req) begin
        if (word_cnt == CNT_FULL) begin
          err <= 1'b1;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= word_cnt[ADDR_W-1:0];
          imem_wdata <= pk_word;
          word_cnt   <= word_cnt + (ADDR_W + 1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: two instances share one stimulus stream, one
// with full memory depth and one with a 4-word memory to exercise overflow.
// A byte-level model predicts every write; monitors pop and compare.
module tb_prog_load_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode_sel = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        a_hold, a_we, a_done, a_err;
  logic [13:0] a_addr;
  logic [31:0] a_wdata;
  logic [14:0] a_cnt;
  logic        b_hold, b_we, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_cnt;

  prog_load_ctrl #(.ADDR_W(14), .TIMEOUT(T)) dut_a (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_hold(a_hold), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .word_cnt(a_cnt), .load_done(a_done), .err(a_err)
  );

  prog_load_ctrl #(.ADDR_W(2), .TIMEOUT(T)) dut_b (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_hold(b_hold), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .word_cnt(b_cnt), .load_done(b_done), .err(b_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  int         cap[2] = '{16384, 4};
  int         m_cnt[2];
  bit         m_err[2];
  logic [7:0] pend[$];
  int         last_acc;
  int         n_pass = 0;
  int         n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: a finished word goes to the next free address of each memory,
  // or raises the overflow flag when that memory is already full.
  function automatic void push_word(input logic [31:0] w, input int c);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (m_cnt[d] < cap[d]) begin
        e.addr = m_cnt[d];
        e.data = w;
        e.cyc  = c;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
        m_cnt[d]++;
      end else begin
        m_err[d] = 1'b1;
      end
    end
  endfunction

  function automatic void flush_model(input int c);
    logic [31:0] w;
    if (pend.size() > 0) begin
      w = '0;
      for (int i = 0; i < pend.size(); i++) w[8*i +: 8] = pend[i];
      push_word(w, c);
      pend.delete();
    end
  endfunction

  function automatic void begin_model();
    m_cnt = '{0, 0};
    m_err = '{1'b0, 1'b0};
    pend.delete();
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One accepted byte; a 4th byte yields a write in the following cycle.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    pend.push_back(b);
    last_acc = cyc + 1;
    if (pend.size() == 4) begin
      push_word({pend[3], pend[2], pend[1], pend[0]}, cyc + 1);
      pend.delete();
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // A byte strobe the controller must ignore (RUN or DONE).
  task automatic poke(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_load();
    mode_sel = 1'b1;
    @(negedge clk);
    begin_model();
    chk("wait_hold", a_hold, 1);
    chk("wait_cnt_clear", a_cnt, 0);
    chk("wait_err_clear_a", a_err, 0);
    chk("wait_err_clear_b", b_err, 0);
    chk("wait_done_low", a_done, 0);
  endtask

  task automatic end_timeout();
    flush_model(last_acc + T);
    idle(T + 2);
    chk("done_a", a_done, 1);
    chk("done_b", b_done, 1);
    chk("done_hold", a_hold, 1);
    chk("done_cnt_a", a_cnt, m_cnt[0]);
    chk("done_cnt_b", b_cnt, m_cnt[1]);
    chk("done_err_a", a_err, m_err[0]);
    chk("done_err_b", b_err, m_err[1]);
  endtask

  task automatic end_mode();
    mode_sel = 1'b0;
    flush_model(cyc + 1);
    idle(4);
    chk("run_hold_a", a_hold, 0);
    chk("run_hold_b", b_hold, 0);
    chk("run_done_low", a_done, 0);
    chk("run_cnt_a", a_cnt, m_cnt[0]);
    chk("run_cnt_b", b_cnt, m_cnt[1]);
    chk("run_err_b", b_err, m_err[1]);
  endtask

  task automatic leave_done();
    mode_sel = 1'b0;
    idle(2);
    chk("release_hold", a_hold, 0);
    chk("release_done", a_done, 0);
  endtask

  // Write monitors: every strobe must match the next predicted write.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_we) begin
      chk("a_write_predicted", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_addr", 32'(a_addr), e.addr);
        chk("a_data", a_wdata, e.data);
        chk("a_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_we) begin
      chk("b_write_predicted", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_addr", 32'(b_addr), e.addr);
        chk("b_data", b_wdata, e.data);
        chk("b_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    begin_model();
    idle(3);
    chk("rst_hold", a_hold, 1);
    chk("rst_we", a_we, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    rst = 1'b1;
    #1;
    chk("idle_hold", a_hold, 1);
    @(negedge clk);
    chk("run_hold", a_hold, 0);
    chk("run_we", a_we, 0);
    chk("run_cnt", a_cnt, 0);

    // Two full words.
    start_load();
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("two_words_cnt", a_cnt, 2);
    end_timeout();
    leave_done();

    // Partial word flushed after timeout; stray bytes in DONE and RUN ignored.
    start_load();
    for (int i = 1; i <= 6; i++) send(8'(i));
    end_timeout();
    chk("flush_cnt", a_cnt, 2);
    poke(8'h55); poke(8'h66);
    leave_done();
    poke(8'h77);
    idle(2);

    // Back-to-back bytes, ended by the switch.
    start_load();
    for (int i = 0; i < 12; i++) send(8'($urandom_range(0, 255)));
    chk("b2b_cnt", a_cnt, 3);
    end_mode();

    // Overflow of the small memory, then err cleared on the next WAIT.
    start_load();
    for (int i = 0; i < 20; i++) begin
      send(8'(8'hA0 + i));
      idle($urandom_range(0, 2));
    end
    chk("ovf_err_b", b_err, 1);
    chk("ovf_cnt_b", b_cnt, 4);
    chk("ovf_cnt_a", a_cnt, 5);
    end_timeout();
    leave_done();
    start_load();
    end_mode();

    // Reset mid-word discards the partial word.
    start_load();
    send(8'h11); send(8'h22);
    rst = 1'b0;
    pend.delete();
    #1;
    chk("abort_hold", a_hold, 1);
    chk("abort_we", a_we, 0);
    chk("abort_addr", a_addr, 0);
    chk("abort_wdata", a_wdata, 0);
    chk("abort_cnt", a_cnt, 0);
    chk("abort_err_b", b_err, 0);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    begin_model();
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("reload_cnt", a_cnt, 1);
    end_mode();

    // Randomized loads with random gaps and endings.
    for (int k = 0; k < 8; k++) begin
      start_load();
      for (int i = $urandom_range(1, 23); i > 0; i--) begin
        send(8'($urandom_range(0, 255)));
        idle($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1) begin
        end_timeout();
        leave_done();
      end else begin
        end_mode();
      end
    end

    idle(5);
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
